servo_pulse_decoder: RTL
========================

// Module: servo_pulse_decoder
// PURPOSE
//  Receive side of the RC-servo PWM interface: measures high time of an incoming
//  50 Hz servo pulse and converts it to a POS_W-bit position. Pin-facing input
//  (async pwm_in), result delivered as a 1-cycle pos_valid strobe to core logic.
//  Detects out-of-range pulses and loss of signal.
// PARAMETERS
//  CLK_HZ         16000000  system clock frequency
//  SERVO_HZ       50        nominal frame rate; frame = CLK_HZ/SERVO_HZ ticks
//  MIN_PULSE_US   1000      pulse width mapped to position 0
//  MAX_PULSE_US   2000      pulse width mapped to position 2^POS_W-1
//  TOL_US         100       tolerance beyond MIN/MAX accepted and clamped
//  POS_W          8         position output width
//  TIMEOUT_FRAMES 3         frames without a rising edge before signal_lost
// PORTS
//  clk            in   1      system clock
//  rst_n          in   1      synchronous active-low reset
//  pwm_in         in   1      servo PWM input, asynchronous
//  position       out  POS_W  last accepted position, held between pulses
//  pos_valid      out  1      1-cycle strobe: position updated this cycle
//  out_of_range   out  1      1-cycle strobe: pulse rejected (too short/long)
//  signal_lost    out  1      level: no rising edge for TIMEOUT_FRAMES frames
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): position=0, pos_valid=0, out_of_range=0,
//    signal_lost=0, FSM->ARM, all counters 0, sync flops cleared to 0.
//  - pwm_in -> 2-flop synchronizer -> s; s_d = s delayed 1; rise=s&~s_d, fall=~s&s_d.
//  - Ticks: MIN_T=MIN_PULSE_US*CLK_HZ/1e6, MAX_T, TOL_T likewise; RANGE=MAX_T-MIN_T.
//  - FSM: ARM: wait for s==0 (never measure a partial pulse) -> IDLE.
//    IDLE: on rise -> HIGH, width=0, acc=0, pos_cnt=0.
//    HIGH: width++ each cycle s==1, saturating at MAX_T+TOL_T+1; on fall -> IDLE
//    and evaluate. Reset mid-pulse returns to ARM.
//  - Position scaling, no divider: while HIGH and width>=MIN_T, acc+=2^POS_W-1;
//    if acc>=RANGE then acc-=RANGE, pos_cnt++ (saturate at 2^POS_W-1).
//    Result = floor((min(width,MAX_T)-MIN_T)*(2^POS_W-1)/RANGE).
//  - Evaluate on fall: MIN_T-TOL_T <= width <= MAX_T+TOL_T -> position<=pos_cnt
//    (0 below MIN_T, full scale above MAX_T), pos_valid=1; else out_of_range=1,
//    position unchanged. Strobes asserted the cycle after fall is detected:
//    exactly 3 clk edges after pwm_in falls. Never both strobes in one cycle.
//  - Timeout: period counter cleared on rise, else increments, saturating;
//    reaching TIMEOUT_FRAMES*frame sets signal_lost (stuck high or stuck low).
//    signal_lost clears on the cycle pos_valid asserts; rise alone does not clear.
//  - Rise and fall cannot coincide (single-bit s). Rise in ARM ignored.
//  - Widths: width ctr $clog2(MAX_T+TOL_T+2); period ctr
//    $clog2(TIMEOUT_FRAMES*CLK_HZ/SERVO_HZ+1); acc $clog2(RANGE+2^POS_W).
// STRUCTURE
//  - servo_pkg: us_to_ticks() function, FRAME_TICKS, default MIN/MAX/TOL constants;
//    shared with servo_driver so both ends agree on timing.
//  - Sub-module pwm_in_sync: 2-flop synchronizer + s_d register, outputs s/rise/fall.
//  - FSM, counters, scaler and output registers live in servo_pulse_decoder.
// TESTING  (defaults; 1 us = 16 clk)
//  - 1500 us pulse every 20 ms -> pos_valid 1 cycle, position=127, 3 clk after fall.
//  - 1000 us -> 0; 2000 us -> 255; 950 us -> 0; 2050 us -> 255 (clamped, valid).
//  - 500 us then 2300 us -> out_of_range strobe each, no pos_valid, position holds.
//  - pwm_in low 960000 clk -> signal_lost=1; next 1500 us pulse -> clears with pos_valid.
//  - rst_n low 5 cycles during 1500 us high -> outputs 0; tail of that pulse yields no
//    strobe; next full pulse decodes normally.
//  - pwm_in high at reset release, falls after 800 us -> no strobe (ARM), next ok.

Source files
------------

// File: rtl/servo_pkg.sv
// Timing helpers and state encoding shared by the servo PWM transmit and receive ends.
package servo_pkg;

  localparam int unsigned DEF_CLK_HZ         = 32'd16000000;
  localparam int unsigned DEF_SERVO_HZ       = 32'd50;
  localparam int unsigned DEF_MIN_PULSE_US   = 32'd1000;
  localparam int unsigned DEF_MAX_PULSE_US   = 32'd2000;
  localparam int unsigned DEF_TOL_US         = 32'd100;
  localparam int unsigned DEF_POS_W          = 32'd8;
  localparam int unsigned DEF_TIMEOUT_FRAMES = 32'd3;

  // 64-bit product: us * CLK_HZ overflows 32 bits at realistic clock rates.
  function automatic int unsigned us_to_ticks(input int unsigned us, input int unsigned clk_hz);
    longint unsigned prod;
    prod = 64'(us) * 64'(clk_hz);
    return 32'(prod / 64'd1000000);
  endfunction

  localparam int unsigned FRAME_TICKS = DEF_CLK_HZ / DEF_SERVO_HZ;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2
  } dec_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Brings the asynchronous servo pin into the clock domain and flags its edges.
module pwm_in_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic s_dly_q;

  // Two-flop synchronizer followed by a one-cycle delay for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
      s_dly_q <= sync2_q;
    end
  end

  assign s_o    = sync2_q;
  assign rise_o = sync2_q & ~s_dly_q;
  assign fall_o = ~sync2_q & s_dly_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo pulse high time and converts it to a position without a divider;
// flags out-of-range pulses and loss of signal.
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned SERVO_HZ       = DEF_SERVO_HZ,
  parameter int unsigned MIN_PULSE_US   = DEF_MIN_PULSE_US,
  parameter int unsigned MAX_PULSE_US   = DEF_MAX_PULSE_US,
  parameter int unsigned TOL_US         = DEF_TOL_US,
  parameter int unsigned POS_W          = DEF_POS_W,
  parameter int unsigned TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [POS_W-1:0] position,
  output logic             pos_valid,
  output logic             out_of_range,
  output logic             signal_lost
);

  localparam int unsigned MIN_T     = us_to_ticks(MIN_PULSE_US, CLK_HZ);
  localparam int unsigned MAX_T     = us_to_ticks(MAX_PULSE_US, CLK_HZ);
  localparam int unsigned TOL_T     = us_to_ticks(TOL_US, CLK_HZ);
  localparam int unsigned RANGE_T   = MAX_T - MIN_T;
  localparam int unsigned FRAME_T   = CLK_HZ / SERVO_HZ;
  localparam int unsigned TIMEOUT_T = TIMEOUT_FRAMES * FRAME_T;

  localparam int W_W = $clog2(MAX_T + TOL_T + 2);
  localparam int P_W = $clog2(TIMEOUT_T + 1);
  localparam int A_W = $clog2(RANGE_T + (2 ** POS_W));

  localparam logic [W_W-1:0]   MIN_W   = W_W'(MIN_T);
  localparam logic [W_W-1:0]   MAX_W   = W_W'(MAX_T);
  localparam logic [W_W-1:0]   LO_W    = W_W'(MIN_T - TOL_T);
  localparam logic [W_W-1:0]   HI_W    = W_W'(MAX_T + TOL_T);
  localparam logic [W_W-1:0]   SAT_W   = W_W'(MAX_T + TOL_T + 1);
  localparam logic [A_W-1:0]   RANGE_A = A_W'(RANGE_T);
  localparam logic [A_W-1:0]   STEP_A  = A_W'((2 ** POS_W) - 1);
  localparam logic [P_W-1:0]   TMO_P   = P_W'(TIMEOUT_T);
  localparam logic [POS_W-1:0] FULL_P  = {POS_W{1'b1}};

  logic s_s;
  logic rise_s;
  logic fall_s;

  pwm_in_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_i  (pwm_in),
    .s_o    (s_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  dec_state_e       state_q;
  logic [1:0]       arm_cnt_q;
  logic [W_W-1:0]   width_q,   width_d;
  logic [A_W-1:0]   acc_q,     acc_d;
  logic [POS_W-1:0] pos_cnt_q, pos_cnt_d;
  logic [P_W-1:0]   period_q,  period_d;
  logic [POS_W-1:0] position_q;
  logic             pos_valid_q;
  logic             oor_q;
  logic             lost_q;
  logic [A_W-1:0]   acc_sum_s;
  logic             in_window_s;
  logic             below_min_s;
  logic             eval_ok_s;

  // Next-state for width, scaler and period counters plus pulse classification
  always_comb begin
    width_d     = width_q;
    acc_d       = acc_q;
    pos_cnt_d   = pos_cnt_q;
    period_d    = period_q;
    acc_sum_s   = acc_q + STEP_A;
    in_window_s = (width_q >= LO_W) && (width_q <= HI_W);
    below_min_s = (width_q < MIN_W);
    eval_ok_s   = (state_q == ST_HIGH) && fall_s && in_window_s;

    if (width_q != SAT_W) begin
      width_d = width_q + 1'b1;
    end else begin
      width_d = width_q;
    end

    // Each tick inside [MIN_T, MAX_T) adds (2^POS_W-1)/RANGE of a position step.
    if ((width_q >= MIN_W) && (width_q < MAX_W)) begin
      if (acc_sum_s >= RANGE_A) begin
        acc_d     = acc_sum_s - RANGE_A;
        pos_cnt_d = (pos_cnt_q == FULL_P) ? pos_cnt_q : pos_cnt_q + 1'b1;
      end else begin
        acc_d     = acc_sum_s;
        pos_cnt_d = pos_cnt_q;
      end
    end else begin
      acc_d     = acc_q;
      pos_cnt_d = pos_cnt_q;
    end

    if (rise_s) begin
      period_d = {P_W{1'b0}};
    end else if (period_q == TMO_P) begin
      period_d = period_q;
    end else begin
      period_d = period_q + 1'b1;
    end
  end

  // Decoder FSM, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ARM;
      arm_cnt_q   <= 2'd0;
      width_q     <= {W_W{1'b0}};
      acc_q       <= {A_W{1'b0}};
      pos_cnt_q   <= {POS_W{1'b0}};
      period_q    <= {P_W{1'b0}};
      position_q  <= {POS_W{1'b0}};
      pos_valid_q <= 1'b0;
      oor_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      pos_valid_q <= 1'b0;
      oor_q       <= 1'b0;
      case (state_q)
        // Synchronizer restarts from 0, so s must stay low long enough to reflect the pin.
        ST_ARM: begin
          if (s_s) begin
            arm_cnt_q <= 2'd0;
          end else if (arm_cnt_q == 2'd2) begin
            arm_cnt_q <= 2'd0;
            state_q   <= ST_IDLE;
          end else begin
            arm_cnt_q <= arm_cnt_q + 2'd1;
          end
        end
        ST_IDLE: begin
          if (rise_s) begin
            state_q   <= ST_HIGH;
            width_q   <= {{(W_W-1){1'b0}}, 1'b1};
            acc_q     <= {A_W{1'b0}};
            pos_cnt_q <= {POS_W{1'b0}};
          end
        end
        ST_HIGH: begin
          if (fall_s) begin
            state_q <= ST_IDLE;
            if (in_window_s) begin
              position_q  <= below_min_s ? {POS_W{1'b0}} : pos_cnt_q;
              pos_valid_q <= 1'b1;
            end else begin
              oor_q <= 1'b1;
            end
          end else begin
            width_q   <= width_d;
            acc_q     <= acc_d;
            pos_cnt_q <= pos_cnt_d;
          end
        end
        default: begin
          state_q <= ST_ARM;
        end
      endcase

      period_q <= period_d;
      if (eval_ok_s) begin
        lost_q <= 1'b0;
      end else if (period_q == TMO_P) begin
        lost_q <= 1'b1;
      end
    end
  end

  assign position     = position_q;
  assign pos_valid    = pos_valid_q;
  assign out_of_range = oor_q;
  assign signal_lost  = lost_q;

endmodule
